// File: rtl/bcd_stopwatch_if.sv
// rtl/bcd_stopwatch_if.sv - command, tick and time-display signals of the BCD stopwatch
interface bcd_stopwatch_if;
    logic       tick;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] sec_lo;
    logic [3:0] sec_hi;
    logic [3:0] min_lo;
    logic [3:0] min_hi;
    logic       running;
    logic       sec_pulse;
    logic       overflow;

    modport master (
        output tick, start, stop, clear,
        input  sec_lo, sec_hi, min_lo, min_hi, running, sec_pulse, overflow
    );

    modport slave (
        input  tick, start, stop, clear,
        output sec_lo, sec_hi, min_lo, min_hi, running, sec_pulse, overflow
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - mm:ss BCD stopwatch counting DIV tick rises per second
module bcd_stopwatch #(
    parameter int unsigned DIV = 100
) (
    input  logic             clkin,
    input  logic             rst,
    bcd_stopwatch_if.slave   sw
);
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        tick_q, tick_d;
    logic [15:0] presc_q, presc_d;
    logic [3:0]  sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
    logic [3:0]  min_lo_q, min_lo_d, min_hi_q, min_hi_d;
    logic        running_q, running_d;
    logic        sec_pulse_q, sec_pulse_d;
    logic        overflow_q, overflow_d;
    logic        rise;
    logic        count;

    assign rise  = sw.tick & ~tick_q;
    // Only a rise seen while already in RUN advances time; start/stop cycles never count.
    assign count = (state_q == RUN) && rise && !sw.clear && !sw.stop;

    always_comb begin
        state_d     = state_q;
        tick_d      = sw.tick;
        presc_d     = presc_q;
        sec_lo_d    = sec_lo_q;
        sec_hi_d    = sec_hi_q;
        min_lo_d    = min_lo_q;
        min_hi_d    = min_hi_q;
        overflow_d  = overflow_q;
        sec_pulse_d = 1'b0;

        if (sw.clear) begin
            state_d    = IDLE;
            presc_d    = '0;
            sec_lo_d   = '0;
            sec_hi_d   = '0;
            min_lo_d   = '0;
            min_hi_d   = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                RUN:       if (sw.stop)  state_d = HALT;
                IDLE, HALT: if (sw.start) state_d = RUN;
                default:   state_d = IDLE;
            endcase

            if (count) begin
                if (presc_q == DIV_M1) begin
                    presc_d     = '0;
                    sec_pulse_d = 1'b1;
                    if (sec_lo_q >= 4'd9) begin
                        sec_lo_d = '0;
                        if (sec_hi_q >= 4'd5) begin
                            sec_hi_d = '0;
                            if (min_lo_q >= 4'd9) begin
                                min_lo_d = '0;
                                if (min_hi_q >= 4'd5) begin
                                    min_hi_d   = '0;
                                    overflow_d = 1'b1;
                                end else begin
                                    min_hi_d = min_hi_q + 4'd1;
                                end
                            end else begin
                                min_lo_d = min_lo_q + 4'd1;
                            end
                        end else begin
                            sec_hi_d = sec_hi_q + 4'd1;
                        end
                    end else begin
                        sec_lo_d = sec_lo_q + 4'd1;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tick_q      <= 1'b0;
            presc_q     <= '0;
            sec_lo_q    <= '0;
            sec_hi_q    <= '0;
            min_lo_q    <= '0;
            min_hi_q    <= '0;
            running_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            presc_q     <= presc_d;
            sec_lo_q    <= sec_lo_d;
            sec_hi_q    <= sec_hi_d;
            min_lo_q    <= min_lo_d;
            min_hi_q    <= min_hi_d;
            running_q   <= running_d;
            sec_pulse_q <= sec_pulse_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sw.sec_lo    = sec_lo_q;
    assign sw.sec_hi    = sec_hi_q;
    assign sw.min_lo    = min_lo_q;
    assign sw.min_hi    = min_hi_q;
    assign sw.running   = running_q;
    assign sw.sec_pulse = sec_pulse_q;
    assign sw.overflow  = overflow_q;
endmodule
